// File: rtl/nibble_serial_subtractor.sv
// Serial wide subtractor: d = a - b - bin, one borrow-lookahead nibble per clock, LSB first.
// Optional zero-result flag port when SUBSER_ZERO_FLAG_EN is defined.
module nibble_serial_subtractor #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   bin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   d,
  output logic                   bout,
`ifdef SUBSER_ZERO_FLAG_EN
  output logic                   zero,
`endif
  output logic                   ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            br_q;
  logic [IW-1:0]   idx;

  logic [3:0]      an;
  logic [3:0]      bn;
  logic [3:0]      g;
  logic [3:0]      p;
  logic [4:0]      br;
  logic [3:0]      dn;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Borrow lookahead across the current nibble, seeded by the registered borrow.
  always_comb begin
    an    = a_q[idx*4 +: 4];
    bn    = b_q[idx*4 +: 4];
    g     = ~an & bn;
    p     = ~(an ^ bn);
    br    = '0;
    br[0] = br_q;
    br[1] = g[0] | (p[0] & br[0]);
    br[2] = g[1] | (p[1] & br[1]);
    br[3] = g[2] | (p[2] & br[2]);
    br[4] = g[3] | (p[3] & br[3]);
    dn    = an ^ bn ^ br[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      br_q  <= 1'b0;
      idx   <= '0;
      d     <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
`ifdef SUBSER_ZERO_FLAG_EN
      zero  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            br_q  <= bin;
            idx   <= '0;
            state <= RUN;
`ifdef SUBSER_ZERO_FLAG_EN
            zero  <= 1'b1;
`endif
          end
        end
        RUN: begin
          d[idx*4 +: 4] <= dn;
          br_q          <= br[4];
`ifdef SUBSER_ZERO_FLAG_EN
          zero          <= zero & (dn == 4'h0);
`endif
          if (idx == LAST) begin
            bout  <= br[4];
            ovf   <= (a_q[W-1] != b_q[W-1]) && (dn[3] != a_q[W-1]);
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed-vector bench for nibble_serial_subtractor (NIBBLES=4).
// Zero flag checks are included when SUBSER_ZERO_FLAG_EN is defined.
module tb_nibble_serial_subtractor;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] d;
  logic        bout;
  logic        ovf;
`ifdef SUBSER_ZERO_FLAG_EN
  logic        zero;
`endif

  int total;
  int bad;

  nibble_serial_subtractor #(.NIBBLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .bin(bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .d(d),
    .bout(bout),
`ifdef SUBSER_ZERO_FLAG_EN
    .zero(zero),
`endif
    .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one operation and waits for out_valid; optionally completes the handshake.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                        input logic ibin, input bit release_res,
                        output int lat);
    a = ia;
    b = ib;
    bin = ibin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (release_res && out_valid) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    total++;
    if (d !== 16'h0000 || bout !== 1'b0 || ovf !== 1'b0) begin
      bad++; $display("FAIL reset_outputs got d=%h bout=%b ovf=%b want 0000 0 0", d, bout, ovf);
    end
`ifdef SUBSER_ZERO_FLAG_EN
    total++;
    if (zero !== 1'b0) begin
      bad++; $display("FAIL reset_zero got=%b want=0", zero);
    end
`endif
  endtask

  task automatic test_equal();
    int lat;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
    total++;
    if (lat !== 4) begin
      bad++; $display("FAIL equal_latency got=%0d want=4", lat);
    end
    total++;
    if (d !== 16'h0000 || bout !== 1'b0 || ovf !== 1'b0) begin
      bad++; $display("FAIL equal_result got d=%h bout=%b ovf=%b want 0000 0 0", d, bout, ovf);
    end
`ifdef SUBSER_ZERO_FLAG_EN
    total++;
    if (zero !== 1'b1) begin
      bad++; $display("FAIL equal_zero got=%b want=1", zero);
    end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL equal_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_ripple();
    int lat;
    run_op(16'h0000, 16'h0001, 1'b0, 1'b0, lat);
    total++;
    if (d !== 16'hFFFF || bout !== 1'b1 || ovf !== 1'b0 || lat !== 4) begin
      bad++; $display("FAIL ripple got d=%h bout=%b ovf=%b lat=%0d want FFFF 1 0 4", d, bout, ovf, lat);
    end
`ifdef SUBSER_ZERO_FLAG_EN
    total++;
    if (zero !== 1'b0) begin
      bad++; $display("FAIL ripple_zero got=%b want=0", zero);
    end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int lat;
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
    total++;
    if (d !== 16'h7FFF || bout !== 1'b0 || ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_neg got d=%h bout=%b ovf=%b want 7FFF 0 1", d, bout, ovf);
    end
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, lat);
    total++;
    if (d !== 16'h8000 || bout !== 1'b1 || ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_pos got d=%h bout=%b ovf=%b want 8000 1 1", d, bout, ovf);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL ovf_release got in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_operand_change();
    int lat;
    a = 16'h1234;
    b = 16'h0234;
    bin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      a = a + 16'h1111;
      b = ~b;
      bin = ~bin;
      tick();
      lat++;
    end
    total++;
    if (d !== 16'h0FFF || bout !== 1'b0 || ovf !== 1'b0 || lat !== 4) begin
      bad++; $display("FAIL operand_change got d=%h bout=%b ovf=%b lat=%0d want 0FFF 0 0 4", d, bout, ovf, lat);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(16'h0000, 16'h0001, 1'b0, 1'b0, lat);
    a = 16'h5555;
    b = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      tick();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || d !== 16'hFFFF || bout !== 1'b1) begin
        bad++;
        $display("FAIL backpressure_hold%0d got ov=%b ir=%b d=%h bout=%b want 1 0 FFFF 1",
                 i, out_valid, in_ready, d, bout);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || d !== 16'hFFFF) begin
      bad++; $display("FAIL backpressure_release got ir=%b ov=%b d=%h want 1 0 FFFF", in_ready, out_valid, d);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    a = 16'h1234;
    b = 16'h0001;
    bin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || d !== 16'h0000) begin
      bad++; $display("FAIL abort_state got ir=%b ov=%b d=%h want 1 0 0000", in_ready, out_valid, d);
    end
    run_op(16'h0005, 16'h0003, 1'b0, 1'b0, lat);
    total++;
    if (d !== 16'h0002 || bout !== 1'b0 || ovf !== 1'b0 || lat !== 4) begin
      bad++; $display("FAIL abort_next got d=%h bout=%b ovf=%b lat=%0d want 0002 0 0 4", d, bout, ovf, lat);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    #2;
    test_reset();
    test_equal();
    test_ripple();
    test_overflow();
    test_operand_change();
    test_backpressure();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
